riscv_parcel_queue: RTL and testbench
=====================================

# riscv_parcel_queue

Parametrised instruction parcel queue between the fetch bus and the decode stage of the RISC-V core. It accepts fetch parcels of any supported width, each with per-halfword valid bits. It compacts the valid halfwords into a circular halfword buffer and presents one aligned instruction per cycle to decode. With `HAS_RVC` set, 16-bit compressed instructions are split out. Fetch misaligned and page-fault flags travel with each halfword.

## Interface
- `XLEN`, 32, width of PC fields.
- `PARCEL_SIZE`, 32, fetch parcel width in bits. Legal values: 16, 32, 64. Lanes: `L = PARCEL_SIZE/16`.
- `DEPTH`, 8, buffer depth in halfwords. Power of two, ≥ 2·L and ≥ 2.
- `HAS_RVC`, 0, 1 enables 16-bit instruction extraction.
- `clk_i` in 1 — clock. One clock domain.
- `rst_i` in 1 — synchronous, active-high reset.
- `flush_i` in 1 — discard all queue contents.
- `parcel_i` in PARCEL_SIZE — fetched data. Lane i is bits [16i+15:16i].
- `parcel_pc_i` in XLEN — address of lane 0.
- `parcel_valid_i` in L — per-lane valid.
- `parcel_misaligned_i` in 1 — fetch misaligned flag. Applies to all valid lanes.
- `parcel_page_fault_i` in 1 — fetch page fault flag. Applies to all valid lanes.
- `ready_o` out 1 — queue can accept a full parcel.
- `instr_o` out 32 — head instruction. A 16-bit instruction is zero-extended.
- `instr_pc_o` out XLEN — PC of the head halfword.
- `instr_rvc_o` out 1 — head instruction is 16-bit.
- `instr_exception_o` out 2 — {page_fault, misaligned}.
- `instr_valid_o` out 1 — head instruction is complete.
- `instr_ready_i` in 1 — decode consumes the head instruction.
- `count_o` out $clog2(DEPTH+1) — occupied halfwords.

## Operation
- **Storage.** DEPTH entries, each {halfword, PC, misaligned, page_fault}. There is a read pointer, a write pointer and a count. Pointers wrap modulo DEPTH.
- **Push.** Push occurs when `ready_o && |parcel_valid_i && !flush_i`.
  - Only valid lanes are written, in ascending lane order, at consecutive slots from the write pointer. Gaps are compacted.
  - Each written entry takes PC = `parcel_pc_i + 2·lane`.
  - The write pointer and count advance by popcount(`parcel_valid_i`).
- `ready_o` = `!rst_i && (DEPTH − count ≥ L)`. It is computed from the registered count only; it does not account for a same-cycle pop.
- **Head decode.** h0 is the entry at the read pointer and h1 is the entry after it.
  - `instr_rvc_o` = `HAS_RVC && count≥1 && h0[1:0]≠2'b11`.
  - RVC case: `instr_o = {16'h0,h0}`, `instr_valid_o = count≥1`, exception = flags(h0).
  - 32-bit case: `instr_o = {h1,h0}` and exception = flags(h0) | flags(h1).
    - `instr_valid_o = count≥2`.
    - It is also set when count==1 and flags(h0) are non-zero. The faulting instruction is presented without waiting for its upper half; in that case `instr_o[31:16]` is 0.
  - `instr_pc_o` = PC(h0).
- **Pop.** Pop occurs when `instr_valid_o && instr_ready_i && !flush_i`. It removes 1 entry if RVC or if the count==1 fault case applies, otherwise 2.
- **Simultaneous push and pop.** Count_next = count + pushed − popped.
- **Flush.** Flush has priority over push, pop and input data. Next cycle: count=0, both pointers=0. The parcel presented in the flush cycle is dropped.
- **Reset.** While reset is asserted, the next cycle has count=0, pointers=0 and all storage entries zeroed. Reset mid-operation discards contents exactly like flush.
- **Outputs after reset.** `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `instr_rvc_o`=0, `instr_exception_o`=0, `count_o`=0, `ready_o`=1 (first cycle after deassertion).

## Timing
- Push to output latency is 1 cycle. A parcel accepted at edge N is visible on `instr_*` after edge N.
- Head outputs are combinational from storage and count. There is no path from `instr_ready_i` or `parcel_*` to `instr_*`.
- `ready_o` depends only on registered state, so there is no combinational loop with fetch.
- Full/empty: count==DEPTH gives `ready_o`=0; count==0 gives `instr_valid_o`=0. No overflow and no underflow is possible.
- Sustained throughput: one instruction per cycle when fetch supplies ≥ 2 halfwords per cycle.

## Test plan
- **Basic 32-bit fetch.** PARCEL_SIZE=32, HAS_RVC=0. Push `0x00A00093` at pc `0x200`, lanes `2'b11`. Next cycle: `instr_valid_o`=1, `instr_o=0x00A00093`, `instr_pc_o=0x200`, `count_o`=2. Pop, then `count_o`=0.
- **RVC split.** HAS_RVC=1. Push `{0x4505,0x0001}` at `0x200`. Head: `instr_o=0x00000001`, rvc=1, pc `0x200`. After pop: `0x00004505`, pc `0x202`, then empty.
- **Straddling instruction.** HAS_RVC=1. Push lanes `2'b10` with `parcel_i[31:16]=0x0093` at pc `0x1FC`. `instr_valid_o` stays 0 with `count_o`=1. Then push `{0x0000,0x00A0}` at `0x200`. Head becomes `0x00A00093`, pc `0x1FE`.
- **Full / back-pressure.** DEPTH=8, L=2, `instr_ready_i`=0. After 4 full pushes, `count_o`=8 and `ready_o`=0; a further push is ignored. One pop of a 32-bit instruction gives `ready_o`=1 the next cycle. Pointer wrap is verified over 20 pushes against a reference model.
- **Flush and reset priority.** Flush together with a valid push and pop. Next cycle: `count_o`=0, `instr_valid_o`=0, and the parcel is not stored. Assert `rst_i` with `count_o`=6: all outputs return to their reset values.
- **Fault propagation.** Push lane `2'b01` with `parcel_page_fault_i`=1 and h0=`0x0093`. Next cycle: `instr_valid_o`=1, `instr_exception_o=2'b10`, `count_o`=1, `instr_o=0x00000093`. One pop empties the queue.

Source files
------------

// File: rtl/riscv_parcel_queue.sv
// rtl/riscv_parcel_queue.sv - fetch parcel to decode halfword queue
// Compacts valid fetch halfwords into a circular buffer and presents one aligned instruction per cycle.
module riscv_parcel_queue #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 8,
  parameter int HAS_RVC     = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [PARCEL_SIZE-1:0]       parcel_i,
  input  logic [XLEN-1:0]              parcel_pc_i,
  input  logic [PARCEL_SIZE/16-1:0]    parcel_valid_i,
  input  logic                         parcel_misaligned_i,
  input  logic                         parcel_page_fault_i,
  output logic                         ready_o,
  output logic [31:0]                  instr_o,
  output logic [XLEN-1:0]              instr_pc_o,
  output logic                         instr_rvc_o,
  output logic [1:0]                   instr_exception_o,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int L  = PARCEL_SIZE / 16;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]     mem_hw  [DEPTH];
  logic [XLEN-1:0] mem_pc  [DEPTH];
  logic            mem_mis [DEPTH];
  logic            mem_pf  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [PW-1:0] lane_slot [L];
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;
  logic          do_push;
  logic          do_pop;

  logic [PW-1:0] h1_idx;
  logic [15:0]   h0_hw;
  logic [15:0]   h1_hw;
  logic [1:0]    h0_flags;
  logic [1:0]    h1_flags;
  logic          has_one;
  logic          has_two;
  logic          head_rvc;
  logic          fault_single;

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < L; i++) begin
      lane_slot[i] = wr_ptr + PW'(push_cnt);
      push_cnt     = push_cnt + CW'(parcel_valid_i[i]);
    end
  end

  assign ready_o = !rst_i && (count <= CW'(DEPTH - L));
  assign do_push = ready_o && (|parcel_valid_i) && !flush_i;

  assign h1_idx   = rd_ptr + PW'(1);
  assign has_one  = (count != '0);
  assign has_two  = (count >= CW'(2));
  assign h0_hw    = mem_hw[rd_ptr];
  assign h0_flags = {mem_pf[rd_ptr], mem_mis[rd_ptr]};
  // The slot after the head is stale unless it is occupied.
  assign h1_hw    = has_two ? mem_hw[h1_idx] : 16'h0;
  assign h1_flags = has_two ? {mem_pf[h1_idx], mem_mis[h1_idx]} : 2'b00;

  assign head_rvc     = (HAS_RVC != 0) && has_one && (h0_hw[1:0] != 2'b11);
  assign fault_single = !head_rvc && (count == CW'(1)) && (h0_flags != 2'b00);

  always_comb begin
    instr_rvc_o = head_rvc;
    instr_pc_o  = mem_pc[rd_ptr];
    if (head_rvc) begin
      instr_o           = {16'h0, h0_hw};
      instr_exception_o = h0_flags;
      instr_valid_o     = has_one;
    end else begin
      instr_o           = {h1_hw, h0_hw};
      instr_exception_o = h0_flags | h1_flags;
      instr_valid_o     = has_two || fault_single;
    end
  end

  assign do_pop  = instr_valid_o && instr_ready_i && !flush_i;
  assign pop_cnt = !do_pop ? CW'(0) : ((head_rvc || fault_single) ? CW'(1) : CW'(2));
  assign count_o = count;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      wr_ptr <= wr_ptr + (do_push ? PW'(push_cnt) : PW'(0));
      count  <= count + (do_push ? push_cnt : CW'(0)) - pop_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_hw[i]  <= '0;
        mem_pc[i]  <= '0;
        mem_mis[i] <= 1'b0;
        mem_pf[i]  <= 1'b0;
      end
    end else if (do_push) begin
      for (int i = 0; i < L; i++) begin
        if (parcel_valid_i[i]) begin
          mem_hw[lane_slot[i]]  <= parcel_i[16*i +: 16];
          mem_pc[lane_slot[i]]  <= parcel_pc_i + XLEN'(2 * i);
          mem_mis[lane_slot[i]] <= parcel_misaligned_i;
          mem_pf[lane_slot[i]]  <= parcel_page_fault_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_parcel_queue.sv
// tb/tb_riscv_parcel_queue.sv - directed and random bench for riscv_parcel_queue
// A halfword queue model derives every expected head, count and ready value.
module tb_riscv_parcel_queue;

  localparam int XLEN        = 32;
  localparam int PARCEL_SIZE = 32;
  localparam int DEPTH       = 8;
  localparam int HAS_RVC     = 1;
  localparam int L           = PARCEL_SIZE / 16;
  localparam int CW          = $clog2(DEPTH + 1);

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   flush_i;
  logic [PARCEL_SIZE-1:0] parcel_i;
  logic [XLEN-1:0]        parcel_pc_i;
  logic [L-1:0]           parcel_valid_i;
  logic                   parcel_misaligned_i;
  logic                   parcel_page_fault_i;
  logic                   ready_o;
  logic [31:0]            instr_o;
  logic [XLEN-1:0]        instr_pc_o;
  logic                   instr_rvc_o;
  logic [1:0]             instr_exception_o;
  logic                   instr_valid_o;
  logic                   instr_ready_i;
  logic [CW-1:0]          count_o;

  always #5 clk_i = ~clk_i;

  riscv_parcel_queue #(
    .XLEN(XLEN), .PARCEL_SIZE(PARCEL_SIZE), .DEPTH(DEPTH), .HAS_RVC(HAS_RVC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .parcel_i(parcel_i), .parcel_pc_i(parcel_pc_i), .parcel_valid_i(parcel_valid_i),
    .parcel_misaligned_i(parcel_misaligned_i), .parcel_page_fault_i(parcel_page_fault_i),
    .ready_o(ready_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_rvc_o(instr_rvc_o),
    .instr_exception_o(instr_exception_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .count_o(count_o)
  );

  typedef struct {
    logic [15:0]     hw;
    logic [XLEN-1:0] pc;
    logic            mis;
    logic            pf;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Head of the halfword queue, derived from the instruction-length rules.
  task automatic model_head(output logic v, output logic [31:0] ins, output logic r,
                            output logic [1:0] exc, output int pops);
    logic [1:0] f0;
    v = 1'b0; ins = '0; r = 1'b0; exc = '0; pops = 0;
    if (q.size() >= 1) begin
      f0 = {q[0].pf, q[0].mis};
      r  = (HAS_RVC != 0) && (q[0].hw[1:0] != 2'b11);
      if (r) begin
        v = 1'b1; ins = {16'h0, q[0].hw}; exc = f0; pops = 1;
      end else if (q.size() >= 2) begin
        v = 1'b1; ins = {q[1].hw, q[0].hw}; exc = f0 | {q[1].pf, q[1].mis}; pops = 2;
      end else if (f0 != 2'b00) begin
        v = 1'b1; ins = {16'h0, q[0].hw}; exc = f0; pops = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic v, r;
    logic [31:0] ins;
    logic [1:0] exc;
    int pops;
    model_head(v, ins, r, exc, pops);
    chk({tag, ".valid"}, instr_valid_o, v);
    chk({tag, ".count"}, count_o, q.size());
    chk({tag, ".ready"}, ready_o, (DEPTH - q.size()) >= L);
    chk({tag, ".rvc"}, instr_rvc_o, r);
    if (v) begin
      chk({tag, ".instr"}, instr_o, ins);
      chk({tag, ".exc"}, instr_exception_o, exc);
      chk({tag, ".pc"}, instr_pc_o, q[0].pc);
    end
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0; parcel_i = '0; parcel_pc_i = '0; parcel_valid_i = '0;
    parcel_misaligned_i = 1'b0; parcel_page_fault_i = 1'b0; instr_ready_i = 1'b0;
  endtask

  // Drives one cycle from a negedge, advances the model, then checks at the next negedge.
  task automatic step(input string tag, input logic [31:0] d, input logic [XLEN-1:0] pc,
                      input logic [L-1:0] vl, input logic mis, input logic pf,
                      input logic rdy, input logic fl);
    logic v, r;
    logic [31:0] ins;
    logic [1:0] exc;
    int pops;
    bit push;
    parcel_i = d; parcel_pc_i = pc; parcel_valid_i = vl;
    parcel_misaligned_i = mis; parcel_page_fault_i = pf;
    instr_ready_i = rdy; flush_i = fl;
    model_head(v, ins, r, exc, pops);
    push = ((DEPTH - q.size()) >= L) && (vl != '0) && !fl;
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      if (v && rdy) repeat (pops) void'(q.pop_front());
      if (push) begin
        for (int i = 0; i < L; i++)
          if (vl[i]) q.push_back('{hw: d[16*i +: 16], pc: pc + XLEN'(2 * i), mis: mis, pf: pf});
      end
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.ready_low", ready_o, 1'b0);
    rst_i = 1'b0;
    q.delete();
    #1;
    chk("rst.valid", instr_valid_o, 1'b0);
    chk("rst.instr", instr_o, 32'h0);
    chk("rst.pc", instr_pc_o, '0);
    chk("rst.rvc", instr_rvc_o, 1'b0);
    chk("rst.exc", instr_exception_o, 2'b00);
    chk("rst.count", count_o, '0);
    chk("rst.ready", ready_o, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic [L-1:0] vl;

    do_reset();

    // Basic aligned 32-bit instruction
    step("basic_push", 32'h00A00093, 32'h200, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("basic.valid", instr_valid_o, 1'b1);
    chk("basic.instr", instr_o, 32'h00A00093);
    chk("basic.pc", instr_pc_o, 32'h200);
    chk("basic.count", count_o, 2);
    step("basic_pop", '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic.empty", count_o, 0);

    // Two compressed instructions in one parcel
    step("rvc_push", 32'h45050001, 32'h200, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rvc.instr0", instr_o, 32'h00000001);
    chk("rvc.rvc0", instr_rvc_o, 1'b1);
    chk("rvc.pc0", instr_pc_o, 32'h200);
    step("rvc_pop0", '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rvc.instr1", instr_o, 32'h00004505);
    chk("rvc.pc1", instr_pc_o, 32'h202);
    step("rvc_pop1", '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rvc.empty", instr_valid_o, 1'b0);

    // 32-bit instruction straddling two parcels
    step("strad_lo", 32'h00930000, 32'h1FC, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("strad.wait_valid", instr_valid_o, 1'b0);
    chk("strad.wait_count", count_o, 1);
    step("strad_hi", 32'h000000A0, 32'h200, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("strad.instr", instr_o, 32'h00A00093);
    chk("strad.pc", instr_pc_o, 32'h1FE);
    step("strad_flush", '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full queue and back-pressure
    for (int k = 0; k < 4; k++)
      step("full_fill", 32'h00100093 + 32'(k << 20), 32'h400 + 32'(4 * k), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full.count", count_o, 8);
    chk("full.ready", ready_o, 1'b0);
    step("full_extra", 32'h12345678, 32'h500, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full.ignored", count_o, 8);
    step("full_pop", '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full.pop_count", count_o, 6);
    chk("full.pop_ready", ready_o, 1'b1);

    // Flush beats a simultaneous push and pop
    step("flush_prio", 32'h00200093, 32'h600, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush.count", count_o, 0);
    chk("flush.valid", instr_valid_o, 1'b0);
    step("flush_after", '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush.dropped", count_o, 0);

    // Reset in the middle of operation
    for (int k = 0; k < 3; k++)
      step("rst_fill", 32'h00300093, 32'h700 + 32'(4 * k), 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid.count", count_o, 6);
    do_reset();

    // Lone faulting halfword presented without its upper half
    step("fault_push", 32'h12340093, 32'h800, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fault.valid", instr_valid_o, 1'b1);
    chk("fault.exc", instr_exception_o, 2'b10);
    chk("fault.count", count_o, 1);
    chk("fault.instr", instr_o, 32'h00000093);
    step("fault_pop", '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fault.empty", count_o, 0);

    // Pointer wrap with back-to-back 32-bit instructions
    for (int k = 0; k < 20; k++) begin
      d = $urandom | 32'h3;
      step("wrap", d, 32'h1000 + 32'(4 * k), 2'b11, 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'b0);
    end

    // Random mixed traffic
    for (int k = 0; k < 400; k++) begin
      d  = $urandom;
      vl = L'($urandom_range(0, 3));
      step("rand", d, $urandom & 32'hFFFF_FFFC, vl,
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
